// File: rtl/input_buffer_mc_if.sv
// Vector enqueue, config and replayed-output signals of input_buffer_mc.
// The master drives enqueue/config, the slave (the buffer) drives the replay outputs.
interface input_buffer_mc_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4,
  parameter int MAX_CHAINS = 4
);
  logic                            enqueue;
  logic                            eof_in;
  logic                            tracing;
  logic                            config_en;
  logic [7:0]                      configId;
  logic [7:0]                      configData;
  logic [N*DATA_WIDTH-1:0]         vector_in;
  logic                            ready_out;
  logic                            valid_out;
  logic                            bof_out;
  logic                            eof_out;
  logic [N*DATA_WIDTH-1:0]         vector_out;
  logic [$clog2(MAX_CHAINS)-1:0]   chainId_out;
  logic [$clog2(IB_DEPTH+1)-1:0]   occupancy;
  logic [15:0]                     drop_count;

  modport master (
    output enqueue, eof_in, tracing, config_en, configId, configData, vector_in,
    input  ready_out, valid_out, bof_out, eof_out, vector_out, chainId_out, occupancy, drop_count
  );

  modport slave (
    input  enqueue, eof_in, tracing, config_en, configId, configData, vector_in,
    output ready_out, valid_out, bof_out, eof_out, vector_out, chainId_out, occupancy, drop_count
  );
endinterface

// File: rtl/input_buffer_mc.sv
// Vector queue replaying each dequeued vector valid_chains times; accept-to-first-beat latency 2 cycles.
// Full queue stalls via ready_out (OVERFLOW_MODE=0) or drops and counts (OVERFLOW_MODE=1).
module input_buffer_mc #(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int IB_DEPTH       = 4,
  parameter int MAX_CHAINS     = 4,
  parameter int OVERFLOW_MODE  = 0,
  parameter int CONFIG_ID      = 0,
  parameter int INITIAL_CHAINS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input_buffer_mc_if.slave    bus
);
  localparam int VW = N * DATA_WIDTH;
  localparam int PW = $clog2(IB_DEPTH);
  localparam int OW = $clog2(IB_DEPTH + 1);
  localparam int CW = $clog2(MAX_CHAINS);
  localparam int KW = $clog2(MAX_CHAINS + 1);

  typedef struct packed {
    logic          eof;
    logic [VW-1:0] vec;
  } entry_t;

  entry_t          mem_q [IB_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   chain_q, chain_d;
  logic [KW-1:0]   vc_q, vc_d;
  logic [KW-1:0]   pend_q, pend_d;
  logic [15:0]     drop_q, drop_d;
  logic            valid_q, valid_d;
  logic            bof_q, bof_d;
  logic            eof_q, eof_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [CW-1:0]   cid_q, cid_d;
  logic            frame_start_q, frame_start_d;

  logic            full, deq, acc, drop_inc;
  logic [KW-1:0]   vc_eff;
  logic [KW-1:0]   chain_inc;
  entry_t          head;

  function automatic logic [KW-1:0] clamp_chains(input logic [7:0] d);
    if (d == 8'd0) begin
      return KW'(1);
    end else if (int'(d) > MAX_CHAINS) begin
      return KW'(MAX_CHAINS);
    end else begin
      return KW'(d);
    end
  endfunction

  assign full      = (occ_q == OW'(IB_DEPTH));
  assign deq       = (chain_q == '0) && (occ_q != '0);
  assign acc       = bus.enqueue && bus.tracing && (!full || deq);
  assign drop_inc  = bus.enqueue && bus.tracing && !acc;
  // A pending chain count only becomes live between vectors, so a replay keeps its length.
  assign vc_eff    = (chain_q == '0) ? pend_q : vc_q;
  assign chain_inc = KW'(chain_q) + KW'(1);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q + OW'(acc) - OW'(deq);
    chain_d       = '0;
    vc_d          = vc_eff;
    pend_d        = pend_q;
    drop_d        = drop_q;
    valid_d       = deq || (chain_q != '0);
    bof_d         = bof_q;
    eof_d         = eof_q;
    vec_d         = vec_q;
    cid_d         = chain_q;
    frame_start_d = frame_start_q;

    if (acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (drop_inc && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    if (bus.config_en && (bus.configId == 8'(CONFIG_ID))) begin
      pend_d = clamp_chains(bus.configData);
    end

    if (chain_q != '0) begin
      chain_d = (chain_inc == vc_q) ? '0 : CW'(chain_inc);
    end else if (deq) begin
      chain_d = (vc_eff > KW'(1)) ? CW'(1) : '0;
    end

    if (deq) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      vec_d         = head.vec;
      eof_d         = head.eof;
      bof_d         = frame_start_q;
      frame_start_d = head.eof;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      chain_q       <= '0;
      vc_q          <= KW'(INITIAL_CHAINS);
      pend_q        <= KW'(INITIAL_CHAINS);
      drop_q        <= '0;
      valid_q       <= 1'b0;
      bof_q         <= 1'b0;
      eof_q         <= 1'b0;
      vec_q         <= '0;
      cid_q         <= '0;
      frame_start_q <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      chain_q       <= chain_d;
      vc_q          <= vc_d;
      pend_q        <= pend_d;
      drop_q        <= drop_d;
      valid_q       <= valid_d;
      bof_q         <= bof_d;
      eof_q         <= eof_d;
      vec_q         <= vec_d;
      cid_q         <= cid_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset_n && acc) begin
      mem_q[wr_ptr_q] <= '{eof: bus.eof_in, vec: bus.vector_in};
    end
  end

  assign bus.ready_out   = (OVERFLOW_MODE != 0) ? 1'b1 : !full;
  assign bus.valid_out   = valid_q;
  assign bus.bof_out     = bof_q;
  assign bus.eof_out     = eof_q;
  assign bus.vector_out  = vec_q;
  assign bus.chainId_out = cid_q;
  assign bus.occupancy   = occ_q;
  assign bus.drop_count  = drop_q;
endmodule
